// File: rtl/reg_file_pkg.sv
// Shared register-file constants and types. The control decoder and the
// writeback mux import the same package so index and word widths agree.
package reg_file_pkg;

    localparam int REG_COUNT = 32;
    localparam int REG_IDX_W = 5;
    localparam int WORD_W    = 32;
    localparam int ZERO_IDX  = 0;

    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file_mux_32_32.sv
// mux_32_32: 32-input, 32-bit wide combinational selector used by both read
// ports of the register file.
module mux_32_32
    import reg_file_pkg::*;
(
    input  logic [REG_COUNT-1:0][WORD_W-1:0] d,
    input  logic [REG_IDX_W-1:0]             sel,
    output logic [WORD_W-1:0]                y
);

    // Pure select; no storage, so a read reflects the register outputs directly.
    always_comb begin
        y = d[sel];
    end

endmodule

// File: rtl/reg_file_reg_32.sv
// reg_32: WIDTH-bit storage register with asynchronous active-high clear and
// a synchronous load enable. One instance backs each architectural register.
module reg_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    // Clear immediately on reset, otherwise load d only when enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit register file, two combinational read ports and one
// edge-triggered write port. Register 0 can be hardwired to zero.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] rw,
    input  logic [WIDTH-1:0]     busW,
    input  logic [REG_IDX_W-1:0] ra,
    input  logic [REG_IDX_W-1:0] rb,
    output logic [WIDTH-1:0]     busA,
    output logic [WIDTH-1:0]     busB
);

    // The read muxes are built for exactly one word width.
    if (WIDTH != WORD_W) begin : g_bad_width
        $error("reg_file: WIDTH must be 32 to match mux_32_32");
    end

    // Outputs of every register slot, gathered for the read muxes.
    logic [REG_COUNT-1:0][WORD_W-1:0] reg_q;

    // One slot per index: the write decoder term (rw == index, gated by we)
    // drives that slot's load enable, so at most one register loads per edge.
    // The zero slot, when hardwired, has no storage and no enable at all,
    // which is what makes writes to index 0 disappear.
    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_slot
        if ((ZERO_REG != 0) && (gi == ZERO_IDX)) begin : g_zero
            assign reg_q[gi] = '0;
        end else begin : g_reg
            logic wr_en;
            assign wr_en = we && (rw == REG_IDX_W'(gi));

            reg_32 #(
                .WIDTH (WORD_W)
            ) u_reg (
                .clk   (clk),
                .reset (reset),
                .en    (wr_en),
                .d     (busW),
                .q     (reg_q[gi])
            );
        end
    end

    // Read ports select straight from register outputs: no bypass, so a
    // same-index write shows up only after the edge.
    mux_32_32 u_mux_a (
        .d   (reg_q),
        .sel (ra),
        .y   (busA)
    );

    mux_32_32 u_mux_b (
        .d   (reg_q),
        .sel (rb),
        .y   (busB)
    );

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: one instance with a hardwired zero register and one
// without, both driven by the same stimulus and checked against an array model.
module tb_reg_file;

    logic        clk     = 1'b0;
    bit          clk_run = 1'b0;
    logic        reset   = 1'b0;
    logic        we      = 1'b0;
    logic [4:0]  rw      = '0;
    logic [31:0] busW    = '0;
    logic [4:0]  ra      = '0;
    logic [4:0]  rb      = '0;
    logic [31:0] busA1, busB1, busA0, busB0;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain arrays of register contents.
    logic [31:0] m1 [32];   // ZERO_REG=1
    logic [31:0] m0 [32];   // ZERO_REG=0

    always #5 if (clk_run) clk = ~clk;

    reg_file #(.WIDTH(32), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset), .we(we), .rw(rw), .busW(busW),
        .ra(ra), .rb(rb), .busA(busA1), .busB(busB1)
    );

    reg_file #(.WIDTH(32), .ZERO_REG(0)) dut_n (
        .clk(clk), .reset(reset), .we(we), .rw(rw), .busW(busW),
        .ra(ra), .rb(rb), .busA(busA0), .busB(busB0)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rw;
        logic [31:0] busw;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea1, eb1, ea0, eb0;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m1[i] = '0;
            m0[i] = '0;
        end
    endtask

    // Both read ports of both instances against the model.
    task automatic check_reads(input string name);
        chk({name, "_z_a"}, busA1, m1[ra]);
        chk({name, "_z_b"}, busB1, m1[rb]);
        chk({name, "_n_a"}, busA0, m0[ra]);
        chk({name, "_n_b"}, busB0, m0[rb]);
    endtask

    task automatic drive(input logic w, input logic [4:0] wi, input logic [31:0] d,
                         input logic [4:0] a, input logic [4:0] b);
        @(negedge clk);
        we   = w;
        rw   = wi;
        busW = d;
        ra   = a;
        rb   = b;
    endtask

    // One rising edge; the model applies the write rule at the same edge.
    task automatic do_edge();
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else if (we) begin
            if (rw != 5'd0) m1[rw] = busW;
            m0[rw] = busW;
        end
        #1;
    endtask

    initial begin
        model_clear();

        // Reset with the clock stopped: every index reads zero.
        #1 reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i);
            rb = 5'(31 - i);
            #1;
            chk("reset_sweep_z_a", busA1, 32'h0);
            chk("reset_sweep_z_b", busB1, 32'h0);
            chk("reset_sweep_n_a", busA0, 32'h0);
            chk("reset_sweep_n_b", busB0, 32'h0);
        end
        $display("reset sweep done with clock stopped");
        #2 reset = 1'b0;
        clk_run = 1'b1;

        // Enable gating: we=0 for three edges leaves reg 9 at zero.
        drive(1'b0, 5'd9, 32'h12345678, 5'd9, 5'd9);
        repeat (3) do_edge();
        chk("we0_hold_z", busA1, 32'h0);
        chk("we0_hold_n", busA0, 32'h0);
        $display("enable gating: reg9 z=%h n=%h", busA1, busA0);

        // Directed vectors; expectations are hand-derived from the write rules.
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd4, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5, 32'h0, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 5'd9,  32'h12345678, 5'd9,  5'd9, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[3] = '{1'b1, 5'd9,  32'h12345678, 5'd9,  5'd5, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 5'd9,  32'hCAFEF00D, 5'd9,  5'd9, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd0, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 32'hFFFFFFFF};
        for (int v = 0; v < 6; v++) begin
            drive(vecs[v].we, vecs[v].rw, vecs[v].busw, vecs[v].ra, vecs[v].rb);
            do_edge();
            chk($sformatf("vec%0d_z_a", v), busA1, vecs[v].ea1);
            chk($sformatf("vec%0d_z_b", v), busB1, vecs[v].eb1);
            chk($sformatf("vec%0d_n_a", v), busA0, vecs[v].ea0);
            chk($sformatf("vec%0d_n_b", v), busB0, vecs[v].eb0);
            check_reads($sformatf("vec%0d_model", v));
            $display("vec%0d we=%b rw=%0d busW=%h ra=%0d rb=%0d -> z:%h/%h n:%h/%h",
                     v, vecs[v].we, vecs[v].rw, vecs[v].busw, vecs[v].ra, vecs[v].rb,
                     busA1, busB1, busA0, busB0);
        end

        // Read-during-write on the same index: old value before the edge.
        drive(1'b1, 5'd7, 32'h11111111, 5'd7, 5'd7);
        do_edge();
        drive(1'b1, 5'd7, 32'h22222222, 5'd0, 5'd7);
        #1;
        chk("rdw_before_z", busB1, 32'h11111111);
        chk("rdw_before_n", busB0, 32'h11111111);
        do_edge();
        chk("rdw_after_z", busB1, 32'h22222222);
        chk("rdw_after_n", busB0, 32'h22222222);
        $display("read-during-write reg7 after edge busB=%h", busB1);

        // Fill regs 1..31 with index*0x01010101 and read mirrored pairs.
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
            do_edge();
        end
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i);
            rb = 5'(31 - i);
            #1;
            chk("fill_z_a", busA1, (i == 0) ? 32'h0 : 32'(i) * 32'h01010101);
            chk("fill_z_b", busB1, (i == 31) ? 32'h0 : 32'(31 - i) * 32'h01010101);
            check_reads("fill_model");
            $display("fill pair ra=%0d rb=%0d busA=%h busB=%h", i, 31 - i, busA1, busB1);
        end

        // Randomized traffic, checked before and after each edge.
        for (int t = 0; t < 300; t++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            #1;
            check_reads("rand_pre");
            do_edge();
            check_reads("rand_post");
            $display("rand%0d we=%b rw=%0d busW=%h ra=%0d rb=%0d busA=%h busB=%h",
                     t, we, rw, busW, ra, rb, busA1, busB1);
        end

        // we=0 with unknown write data: nothing changes.
        for (int t = 0; t < 4; t++) begin
            drive(1'b0, 5'(t + 1), 'x, 5'(t + 1), 5'(31 - t));
            do_edge();
            check_reads("we0_xdata");
            $display("we0 xdata rw=%0d busA=%h", t + 1, busA1);
        end

        // Asynchronous reset between edges with a write pending.
        drive(1'b1, 5'd3, 32'h33333333, 5'd3, 5'd3);
        #2 reset = 1'b1;
        model_clear();
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i);
            rb = 5'(31 - i);
            #1;
            chk("async_rst_z_a", busA1, 32'h0);
            chk("async_rst_z_b", busB1, 32'h0);
            chk("async_rst_n_a", busA0, 32'h0);
            chk("async_rst_n_b", busB0, 32'h0);
        end
        ra = 5'd3;
        do_edge();
        chk("rst_held_edge_z", busA1, 32'h0);
        chk("rst_held_edge_n", busA0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_release_pre_z", busA1, 32'h0);
        do_edge();
        chk("rst_release_write_z", busA1, 32'h33333333);
        chk("rst_release_write_n", busA0, 32'h33333333);
        check_reads("rst_release_model");
        $display("reset release write reg3 busA=%h", busA1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the clocking ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
